// File: rtl/vga_pkg.sv
// 1024x768@60 timing constants plus the types shared by the sync tracker.
package vga_pkg;

   localparam int HL_BLANK_START = 1024;
   localparam int HL_SYNC_START  = 1048;
   localparam int HL_SYNC_END    = 1184;
   localparam int HL_TOTAL_TIME  = 1344;

   localparam int VL_BLANK_START = 768;
   localparam int VL_SYNC_START  = 771;
   localparam int VL_SYNC_END    = 777;
   localparam int VL_TOTAL_TIME  = 806;

   localparam int CNT_W = 11;

   // bit positions inside the predictor mismatch vector
   localparam int MM_HS = 0;
   localparam int MM_HB = 1;
   localparam int MM_VS = 2;
   localparam int MM_VB = 3;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      H_ALIGN = 2'd1,
      V_ALIGN = 2'd2,
      LOCKED  = 2'd3
   } tracker_state_t;

endpackage

// File: rtl/vga_pos_predictor.sv
// Predicts the position of the current sample from free-running h/v counters
// (with sync-edge reloads) and flags inputs that disagree with that position.
module vga_pos_predictor
   import vga_pkg::*;
#(
   parameter int H_BLANK_START = HL_BLANK_START,
   parameter int H_SYNC_START  = HL_SYNC_START,
   parameter int H_SYNC_END    = HL_SYNC_END,
   parameter int H_TOTAL       = HL_TOTAL_TIME,
   parameter int V_BLANK_START = VL_BLANK_START,
   parameter int V_SYNC_START  = VL_SYNC_START,
   parameter int V_SYNC_END    = VL_SYNC_END,
   parameter int V_TOTAL       = VL_TOTAL_TIME
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             h_reload,
   input  logic             v_reload,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic             hblnk_in,
   input  logic             vblnk_in,
   output logic [CNT_W-1:0] pos_h,
   output logic [CNT_W-1:0] pos_v,
   output logic [3:0]       mismatch
);

   localparam logic [CNT_W-1:0] H_BS   = CNT_W'(H_BLANK_START);
   localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_SYNC_START);
   localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_SYNC_END);
   localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_BS   = CNT_W'(V_BLANK_START);
   localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_SYNC_START);
   localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_SYNC_END);
   localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);

   logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
   logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
   logic             exp_hs, exp_hb, exp_vs, exp_vb;

   always_comb begin
      pos_h   = h_reload ? H_SS : h_cnt_q;
      pos_v   = v_reload ? V_SS : v_cnt_q;
      h_cnt_d = (pos_h == H_LAST) ? '0 : pos_h + CNT_W'(1);
      v_cnt_d = pos_v;
      if (pos_h == H_LAST) begin
         v_cnt_d = (pos_v == V_LAST) ? '0 : pos_v + CNT_W'(1);
      end

      // half-open ranges; blanking runs to the end of the line/frame
      exp_hs = (pos_h >= H_SS) && (pos_h < H_SE);
      exp_hb = (pos_h >= H_BS) && (pos_h <= H_LAST);
      exp_vs = (pos_v >= V_SS) && (pos_v < V_SE);
      exp_vb = (pos_v >= V_BS) && (pos_v <= V_LAST);

      mismatch        = '0;
      mismatch[MM_HS] = hsync_in ^ exp_hs;
      mismatch[MM_HB] = hblnk_in ^ exp_hb;
      mismatch[MM_VS] = vsync_in ^ exp_vs;
      mismatch[MM_VB] = vblnk_in ^ exp_vb;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt_q <= '0;
         v_cnt_q <= '0;
      end else begin
         h_cnt_q <= h_cnt_d;
         v_cnt_q <= v_cnt_d;
      end
   end

endmodule

// File: rtl/vga_sync_tracker.sv
// Rebuilds hcount/vcount from a sync/blank stream, declares lock after clean
// frames and counts timing errors once aligned.
//
// state   | meaning
// HUNT    | waiting for an hsync rising edge
// H_ALIGN | horizontal phase known, checking h, waiting for vsync edge
// V_ALIGN | fully aligned, counting clean vsync edges toward lock
// LOCKED  | stream trusted; any mismatch is an error and drops lock
module vga_sync_tracker
   import vga_pkg::*;
#(
   parameter int LOCK_FRAMES   = 2,
   parameter int ERR_W         = 8,
   parameter int H_BLANK_START = HL_BLANK_START,
   parameter int H_SYNC_START  = HL_SYNC_START,
   parameter int H_SYNC_END    = HL_SYNC_END,
   parameter int H_TOTAL       = HL_TOTAL_TIME,
   parameter int V_BLANK_START = VL_BLANK_START,
   parameter int V_SYNC_START  = VL_SYNC_START,
   parameter int V_SYNC_END    = VL_SYNC_END,
   parameter int V_TOTAL       = VL_TOTAL_TIME
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hsync_in,
   input  logic             vsync_in,
   input  logic             hblnk_in,
   input  logic             vblnk_in,
   output logic [CNT_W-1:0] hcount_out,
   output logic [CNT_W-1:0] vcount_out,
   output logic             h_valid,
   output logic             locked,
   output logic             frame_start,
   output logic             timing_err,
   output logic [ERR_W-1:0] err_cnt
);

   localparam int GF_W = (LOCK_FRAMES < 2) ? 1 : $clog2(LOCK_FRAMES + 1);

   tracker_state_t   state_q, state_d;
   logic [GF_W-1:0]  good_frames_q, good_frames_d, gf_inc;
   logic             hsync_d_q, vsync_d_q;
   logic             hs_rise, vs_rise, h_reload, v_reload;
   logic             mm_h, mm_any, err_now;
   logic [CNT_W-1:0] pos_h, pos_v;
   logic [3:0]       mismatch;

   logic [CNT_W-1:0] hcount_q, vcount_q;
   logic             h_valid_q, h_valid_d;
   logic             locked_q, locked_d;
   logic             frame_start_q, frame_start_d;
   logic             timing_err_q;
   logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

   assign hs_rise  = hsync_in & ~hsync_d_q;
   assign vs_rise  = vsync_in & ~vsync_d_q;
   assign h_reload = hs_rise && ((state_q == HUNT) || (state_q == H_ALIGN));
   assign v_reload = vs_rise && (state_q == H_ALIGN);

   vga_pos_predictor #(
      .H_BLANK_START (H_BLANK_START),
      .H_SYNC_START  (H_SYNC_START),
      .H_SYNC_END    (H_SYNC_END),
      .H_TOTAL       (H_TOTAL),
      .V_BLANK_START (V_BLANK_START),
      .V_SYNC_START  (V_SYNC_START),
      .V_SYNC_END    (V_SYNC_END),
      .V_TOTAL       (V_TOTAL)
   ) u_pred (
      .clk      (clk),
      .rst      (rst),
      .h_reload (h_reload),
      .v_reload (v_reload),
      .hsync_in (hsync_in),
      .vsync_in (vsync_in),
      .hblnk_in (hblnk_in),
      .vblnk_in (vblnk_in),
      .pos_h    (pos_h),
      .pos_v    (pos_v),
      .mismatch (mismatch)
   );

   assign mm_h   = mismatch[MM_HS] | mismatch[MM_HB];
   assign mm_any = |mismatch;
   assign gf_inc = good_frames_q + GF_W'(1);

   always_comb begin
      state_d       = state_q;
      good_frames_d = good_frames_q;
      err_now       = 1'b0;
      case (state_q)
         HUNT: begin
            if (hs_rise) state_d = H_ALIGN;
         end
         H_ALIGN: begin
            if (mm_h) begin
               state_d = HUNT;
            end else if (vs_rise) begin
               state_d       = V_ALIGN;
               good_frames_d = '0;
            end
         end
         V_ALIGN: begin
            // a mismatch wins over a lock-qualifying vsync edge
            if (mm_any) begin
               err_now = 1'b1;
               state_d = HUNT;
            end else if (vs_rise) begin
               good_frames_d = gf_inc;
               if (gf_inc == GF_W'(LOCK_FRAMES)) state_d = LOCKED;
            end
         end
         LOCKED: begin
            if (mm_any) begin
               err_now = 1'b1;
               state_d = HUNT;
            end
         end
         default: state_d = HUNT;
      endcase

      err_cnt_d = err_cnt_q;
      if (err_now && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + ERR_W'(1);

      h_valid_d     = (state_d != HUNT);
      locked_d      = (state_d == LOCKED);
      frame_start_d = (state_d == LOCKED) && (pos_h == '0) && (pos_v == '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= HUNT;
         good_frames_q <= '0;
         // start high so a sync already asserted is not seen as an edge
         hsync_d_q     <= 1'b1;
         vsync_d_q     <= 1'b1;
         hcount_q      <= '0;
         vcount_q      <= '0;
         h_valid_q     <= 1'b0;
         locked_q      <= 1'b0;
         frame_start_q <= 1'b0;
         timing_err_q  <= 1'b0;
         err_cnt_q     <= '0;
      end else begin
         state_q       <= state_d;
         good_frames_q <= good_frames_d;
         hsync_d_q     <= hsync_in;
         vsync_d_q     <= vsync_in;
         hcount_q      <= pos_h;
         vcount_q      <= pos_v;
         h_valid_q     <= h_valid_d;
         locked_q      <= locked_d;
         frame_start_q <= frame_start_d;
         timing_err_q  <= err_now;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign hcount_out  = hcount_q;
   assign vcount_out  = vcount_q;
   assign h_valid     = h_valid_q;
   assign locked      = locked_q;
   assign frame_start = frame_start_q;
   assign timing_err  = timing_err_q;
   assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_vga_sync_tracker.sv
// Scoreboard bench for vga_sync_tracker on a shrunken 16x10 raster so that
// several full frames fit in a short run.
module tb_vga_sync_tracker;

   localparam int HB = 8,  HS = 10, HE = 12, HT = 16;
   localparam int VB = 6,  VS = 7,  VE = 8,  VT = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
   logic [10:0] hcount_out, vcount_out;
   logic        h_valid, locked, frame_start, timing_err;
   logic [7:0]  err_cnt;

   always #5 clk = ~clk;

   vga_sync_tracker #(
      .LOCK_FRAMES(2), .ERR_W(8),
      .H_BLANK_START(HB), .H_SYNC_START(HS), .H_SYNC_END(HE), .H_TOTAL(HT),
      .V_BLANK_START(VB), .V_SYNC_START(VS), .V_SYNC_END(VE), .V_TOTAL(VT)
   ) dut (
      .clk(clk), .rst(rst),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .hcount_out(hcount_out), .vcount_out(vcount_out), .h_valid(h_valid),
      .locked(locked), .frame_start(frame_start), .timing_err(timing_err),
      .err_cnt(err_cnt)
   );

   typedef enum int {K_HC, K_VC, K_VALID, K_LOCK, K_FS, K_TERR, K_ECNT} kind_t;
   typedef struct {int tag; kind_t kind; int val;} exp_t;
   typedef struct {int f; int h; int v; kind_t kind; int val;} vec_t;

   exp_t sb[$];
   vec_t vecs[$];
   int   sample_no = 0;
   int   errors = 0;
   int   checks = 0;
   int   drop_hs_f = -1, drop_hs_l = -1, vs_shift_f = -1;
   int   rst_f = -1, rst_h = -1, rst_v = -1, full_f = -1;

   function automatic void av(int f, int h, int v, kind_t k, int val);
      vecs.push_back('{f, h, v, k, val});
   endfunction

   function automatic void expect_next(kind_t k, int val);
      sb.push_back('{sample_no + 1, k, val});
   endfunction

   function automatic int act_of(kind_t k);
      case (k)
         K_HC:    return int'(hcount_out);
         K_VC:    return int'(vcount_out);
         K_VALID: return int'(h_valid);
         K_LOCK:  return int'(locked);
         K_FS:    return int'(frame_start);
         K_TERR:  return int'(timing_err);
         K_ECNT:  return int'(err_cnt);
         default: return -1;
      endcase
   endfunction

   task automatic drive(bit r, bit hs, bit vs, bit hb, bit vb);
      rst = r; hsync_in = hs; vsync_in = vs; hblnk_in = hb; vblnk_in = vb;
      @(posedge clk);
      sample_no++;
      #1;
   endtask

   task automatic stream_pix(int f, int h, int v);
      bit hs, vs, hb, vb, r;
      hs = (h >= HS) && (h < HE);
      hb = (h >= HB);
      vs = (v >= VS) && (v < VE);
      vb = (v >= VB);
      r  = 1'b0;
      if (f == drop_hs_f && v == drop_hs_l) hs = 1'b0;
      if (f == vs_shift_f) vs = (v == VS + 1);
      if (f == rst_f && h == rst_h && v == rst_v) r = 1'b1;
      foreach (vecs[i])
         if (vecs[i].f == f && vecs[i].h == h && vecs[i].v == v)
            expect_next(vecs[i].kind, vecs[i].val);
      if (f == full_f) begin
         expect_next(K_HC, h);
         expect_next(K_VC, v);
      end
      drive(r, hs, vs, hb, vb);
   endtask

   always @(negedge clk) begin
      exp_t e;
      int   a;
      while (sb.size() > 0 && sb[0].tag <= sample_no) begin
         e = sb.pop_front();
         a = act_of(e.kind);
         checks++;
         if (e.tag != sample_no) begin
            errors++;
            $display("FAIL stale_%s tag=%0d now=%0d", e.kind.name(), e.tag, sample_no);
         end else if (a != e.val) begin
            errors++;
            $display("FAIL %s sample=%0d got=%0d exp=%0d", e.kind.name(), sample_no, a, e.val);
         end
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog expired at sample %0d", sample_no);
      $fatal(1, "timeout");
   end

   initial begin
      // acquisition from (0,0)
      av(0, 9, 0, K_VALID, 0);  av(0, 10, 0, K_VALID, 1); av(0, 10, 0, K_HC, 10);
      av(2, 0, 0, K_FS, 0);     av(2, 15, 6, K_LOCK, 0);  av(2, 0, 7, K_LOCK, 1);
      av(3, 0, 0, K_FS, 1);     av(3, 1, 0, K_FS, 0);     av(3, 15, 9, K_ECNT, 0);
      // dropped hsync pulse in frame 4 line 2, relock on frame 6 edge
      av(4, 9, 2, K_LOCK, 1);   av(4, 9, 2, K_TERR, 0);
      av(4, 10, 2, K_TERR, 1);  av(4, 10, 2, K_LOCK, 0);  av(4, 10, 2, K_ECNT, 1);
      av(4, 11, 2, K_TERR, 0);
      av(6, 15, 6, K_LOCK, 0);  av(6, 0, 7, K_LOCK, 1);   av(6, 1, 7, K_ECNT, 1);
      // one-cycle reset while locked, relock on frame 9 edge
      av(7, 15, 2, K_LOCK, 1);
      av(7, 0, 3, K_LOCK, 0);   av(7, 0, 3, K_VALID, 0);  av(7, 0, 3, K_HC, 0);
      av(7, 0, 3, K_VC, 0);     av(7, 0, 3, K_ECNT, 0);   av(7, 0, 3, K_TERR, 0);
      av(7, 0, 3, K_FS, 0);
      av(7, 10, 3, K_VALID, 1); av(7, 10, 3, K_HC, 10);
      av(9, 15, 6, K_LOCK, 0);  av(9, 0, 7, K_LOCK, 1);   av(9, 1, 7, K_ECNT, 0);
      // vsync start shifted one line late in frame 10
      av(10, 15, 6, K_LOCK, 1); av(10, 15, 6, K_TERR, 0);
      av(10, 0, 7, K_TERR, 1);  av(10, 0, 7, K_LOCK, 0);  av(10, 0, 7, K_ECNT, 1);
      av(10, 1, 7, K_VALID, 0); av(10, 1, 7, K_TERR, 0);
      // mid-line entry after reset
      av(99, 9, 3, K_VALID, 0); av(99, 10, 3, K_VALID, 1); av(99, 10, 3, K_HC, 10);

      drive(1, 0, 0, 0, 0);
      expect_next(K_HC, 0);    expect_next(K_VC, 0);    expect_next(K_VALID, 0);
      expect_next(K_LOCK, 0);  expect_next(K_FS, 0);    expect_next(K_TERR, 0);
      expect_next(K_ECNT, 0);
      drive(1, 0, 0, 0, 0);

      drop_hs_f = 4; drop_hs_l = 2; vs_shift_f = 10;
      rst_f = 7; rst_h = 0; rst_v = 3; full_f = 3;
      for (int f = 0; f <= 10; f++)
         for (int v = 0; v < VT; v++)
            for (int h = 0; h < HT; h++)
               stream_pix(f, h, v);
      drop_hs_f = -1; vs_shift_f = -1; rst_f = -1; full_f = -1;

      // burst of errors: reset, then hsync edge / vsync edge / bad vsync / idle
      expect_next(K_ECNT, 0);
      expect_next(K_LOCK, 0);
      drive(1, 0, 0, 1, 1);
      drive(0, 0, 0, 1, 1);
      for (int n = 1; n <= 300; n++) begin
         drive(0, 1, 0, 1, 1);
         drive(0, 1, 1, 1, 1);
         expect_next(K_TERR, 1);
         expect_next(K_ECNT, (n > 255) ? 255 : n);
         drive(0, 0, 0, 1, 1);
         if (n == 300) expect_next(K_TERR, 0);
         drive(0, 0, 0, 1, 1);
      end

      drive(1, 0, 0, 0, 0);
      for (int h = 5; h <= 12; h++) stream_pix(99, h, 3);

      drive(0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
